cc_bus_read_arbiter: RTL and testbench

- Shares the 14-source register-read multiplexer (g0..g7, PC, Temp0..Temp3, IR; 4-bit select) among NUM_REQ independent requesters, e.g. microsequencer, ALU operand fetch, debug port, memory-address unit.
- Round-robin arbitration picks one requester.
- The block drives the mux select code, captures the mux output one cycle later, and returns the data with a one-cycle ack pulse.
- Sits between the requesters and the mux in the datapath top level.

---
 rtl/cc_datapath_pkg.sv | 28 ++
 rtl/cc_rr_picker.sv | 35 +++
 rtl/cc_bus_read_arbiter.sv | 113 +++++++++++
 tb/tb_cc_bus_read_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_datapath_pkg.sv
// Shared datapath constants: register-read mux select codes and the read-arbiter FSM encoding.
package cc_datapath_pkg;

  localparam logic [3:0] SEL_G0            = 4'h0;
  localparam logic [3:0] SEL_G1            = 4'h1;
  localparam logic [3:0] SEL_G2            = 4'h2;
  localparam logic [3:0] SEL_G3            = 4'h3;
  localparam logic [3:0] SEL_G4            = 4'h4;
  localparam logic [3:0] SEL_G5            = 4'h5;
  localparam logic [3:0] SEL_G6            = 4'h6;
  localparam logic [3:0] SEL_G7            = 4'h7;
  localparam logic [3:0] SEL_PC            = 4'h8;
  localparam logic [3:0] SEL_TEMP0         = 4'h9;
  localparam logic [3:0] SEL_TEMP1         = 4'hA;
  localparam logic [3:0] SEL_TEMP2         = 4'hB;
  localparam logic [3:0] SEL_TEMP3         = 4'hC;
  localparam logic [3:0] SEL_IR            = 4'hD;
  localparam logic [3:0] SEL_FIRST_ILLEGAL = 4'hE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  function automatic logic sel_is_illegal(input logic [3:0] code);
    return code >= SEL_FIRST_ILLEGAL;
  endfunction

endpackage

// File: rtl/cc_rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping modulo NUM_REQ.
module cc_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [2*NUM_REQ-1:0] rot;
  logic [IDX_W:0]       sum;
  logic                 found;

  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    found    = 1'b0;
    sum      = '0;
    // Doubling the vector turns the wrap-around scan into a plain shift.
    rot      = {req_i, req_i} >> ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_REQ))
          winner_o = IDX_W'(sum - (IDX_W+1)'(NUM_REQ));
        else
          winner_o = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/cc_bus_read_arbiter.sv
// Round-robin arbiter sharing the register-read mux: select, capture one cycle later, ack with data.
module cc_bus_read_arbiter
  import cc_datapath_pkg::*;
#(
  parameter int NUM_REQ                 = 4,
  parameter int DATAWIDTH_MUX_SELECTION = 4,
  parameter int DATAWIDTH_BUS           = 32
) (
  input  logic                                       CC_ARB_CLOCK_50,
  input  logic                                       CC_ARB_RESET_InHigh,
  input  logic [NUM_REQ-1:0]                         CC_ARB_Req_In,
  input  logic [NUM_REQ*DATAWIDTH_MUX_SELECTION-1:0] CC_ARB_Addr_In,
  input  logic [DATAWIDTH_BUS-1:0]                   CC_ARB_MuxData_In,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]         CC_ARB_MuxSel_Out,
  output logic [NUM_REQ-1:0]                         CC_ARB_Ack_Out,
  output logic [DATAWIDTH_BUS-1:0]                   CC_ARB_Data_Out,
  output logic                                       CC_ARB_Err_Out,
  output logic                                       CC_ARB_Busy_Out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]                         state_q, state_d;
  logic [IDX_W-1:0]                   ptr_q, ptr_d;
  logic [IDX_W-1:0]                   win_q, win_d;
  logic                               illegal_q, illegal_d;
  logic [DATAWIDTH_MUX_SELECTION-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0]                 ack_q, ack_d;
  logic [DATAWIDTH_BUS-1:0]           data_q, data_d;
  logic                               err_q, err_d;

  logic                               pick_any;
  logic [IDX_W-1:0]                   pick_win;
  logic [DATAWIDTH_MUX_SELECTION-1:0] pick_addr;

  cc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (CC_ARB_Req_In),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_win)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_win == IDX_W'(i))
        pick_addr = CC_ARB_Addr_In[i*DATAWIDTH_MUX_SELECTION +: DATAWIDTH_MUX_SELECTION];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    illegal_d = illegal_q;
    sel_d     = sel_q;
    data_d    = data_q;
    ack_d     = '0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d     = pick_addr;
          win_d     = pick_win;
          illegal_d = sel_is_illegal(pick_addr);
          state_d   = ST_SEL;
        end
      end
      ST_SEL: state_d = ST_CAPT;
      ST_CAPT: begin
        data_d = illegal_q ? '0 : CC_ARB_MuxData_In;
        err_d  = illegal_q;
        for (int i = 0; i < NUM_REQ; i++)
          ack_d[i] = (win_q == IDX_W'(i));
        ptr_d   = (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CC_ARB_CLOCK_50 or posedge CC_ARB_RESET_InHigh) begin
    if (CC_ARB_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      illegal_q <= 1'b0;
      sel_q     <= '0;
      ack_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      illegal_q <= illegal_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign CC_ARB_MuxSel_Out = sel_q;
  assign CC_ARB_Ack_Out    = ack_q;
  assign CC_ARB_Data_Out   = data_q;
  assign CC_ARB_Err_Out    = err_q;
  assign CC_ARB_Busy_Out   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cc_bus_read_arbiter.sv
// Self-checking bench for cc_bus_read_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_cc_bus_read_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] addr;
  logic [31:0] mux_data;
  logic [3:0]  mux_sel;
  logic [3:0]  ack;
  logic [31:0] data;
  logic        err;
  logic        busy;
  logic [31:0] mux_table [16];

  int checks;
  int failures;

  cc_bus_read_arbiter #(
    .NUM_REQ                 (4),
    .DATAWIDTH_MUX_SELECTION (4),
    .DATAWIDTH_BUS           (32)
  ) dut (
    .CC_ARB_CLOCK_50     (clk),
    .CC_ARB_RESET_InHigh (rst),
    .CC_ARB_Req_In       (req),
    .CC_ARB_Addr_In      (addr),
    .CC_ARB_MuxData_In   (mux_data),
    .CC_ARB_MuxSel_Out   (mux_sel),
    .CC_ARB_Ack_Out      (ack),
    .CC_ARB_Data_Out     (data),
    .CC_ARB_Err_Out      (err),
    .CC_ARB_Busy_Out     (busy)
  );

  // Register-read mux model: combinational lookup on the select code.
  assign mux_data = mux_table[mux_sel];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = '0;
    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    #3;
    checks++;
    if ({mux_sel, ack, data, err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got sel=%h ack=%b data=%h err=%b busy=%b exp all zero",
               mux_sel, ack, data, err, busy);
    end
    apply_reset();
  endtask

  task automatic test_single();
    mux_table[8] = 32'h0000_0040;
    req  = 4'b0001;
    addr = 16'h0008;
    step();
    checks++;
    if (mux_sel !== 4'h8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_sel got sel=%h busy=%b exp sel=8 busy=1", mux_sel, busy);
    end
    step();
    step();
    checks++;
    if (ack !== 4'b0001 || data !== 32'h40 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_ack got ack=%b data=%h err=%b exp ack=0001 data=40 err=0", ack, data, err);
    end
    req = '0;
    step();
    checks++;
    if (ack !== 4'b0000 || data !== 32'h40) begin
      failures++;
      $display("FAIL single_ack_clear got ack=%b data=%h exp ack=0000 data=40", ack, data);
    end
  endtask

  task automatic test_rotation();
    int cnt;
    int exp_w;
    logic [3:0] exp_ack;
    apply_reset();
    for (int s = 0; s < 16; s++) mux_table[s] = 32'hA0 + s;
    req  = 4'b1111;
    addr = 16'h3210;
    for (int n = 0; n < 5; n++) begin
      exp_w   = n % 4;
      exp_ack = 4'b0001 << exp_w;
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (ack === 4'b0000 && cnt < 8);
      checks++;
      if (cnt != 3) begin
        failures++;
        $display("FAIL rotation_spacing n=%0d got cycles=%0d exp 3", n, cnt);
      end
      checks++;
      if (ack !== exp_ack || data !== 32'hA0 + exp_w) begin
        failures++;
        $display("FAIL rotation_grant n=%0d got ack=%b data=%h exp ack=%b data=%h",
                 n, ack, data, exp_ack, 32'hA0 + exp_w);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_pointer();
    apply_reset();
    req  = 4'b0010;
    addr = 16'h0050;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL pointer_setup got ack=%b exp 0010", ack);
    end
    req = 4'b0011;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL pointer_wrap_first got ack=%b exp 0001", ack);
    end
    req = 4'b0010;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL pointer_wrap_second got ack=%b exp 0010", ack);
    end
    req = 4'b1111;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0100) begin
      failures++;
      $display("FAIL pointer_final got ack=%b exp 0100 (pointer 2)", ack);
    end
    req = '0;
    step();
  endtask

  task automatic test_illegal();
    mux_table[13] = 32'h0000_1234;
    mux_table[15] = 32'hDEAD_BEEF;
    mux_table[14] = 32'hCAFE_F00D;
    req  = 4'b0100;
    addr = 16'h0D00;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0100 || err !== 1'b0 || data !== 32'h1234) begin
      failures++;
      $display("FAIL illegal_edge_legal got ack=%b err=%b data=%h exp ack=0100 err=0 data=1234", ack, err, data);
    end
    req  = 4'b0100;
    addr = 16'h0F00;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0100 || err !== 1'b1 || data !== 32'h0) begin
      failures++;
      $display("FAIL illegal_f got ack=%b err=%b data=%h exp ack=0100 err=1 data=0", ack, err, data);
    end
    req = '0;
    step();
    checks++;
    if (ack !== 4'b0000 || err !== 1'b0 || data !== 32'h0) begin
      failures++;
      $display("FAIL illegal_clear got ack=%b err=%b data=%h exp ack=0000 err=0 data=0", ack, err, data);
    end
    req  = 4'b1000;
    addr = 16'hE000;
    repeat (3) step();
    checks++;
    if (ack !== 4'b1000 || err !== 1'b1 || data !== 32'h0) begin
      failures++;
      $display("FAIL illegal_e got ack=%b err=%b data=%h exp ack=1000 err=1 data=0", ack, err, data);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    mux_table[3] = 32'h33;
    mux_table[6] = 32'h66;
    apply_reset();
    req  = 4'b0001;
    addr = 16'h0036;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0001 || data !== 32'h66) begin
      failures++;
      $display("FAIL resetmid_pre got ack=%b data=%h exp ack=0001 data=66", ack, data);
    end
    req = 4'b0010;
    step();
    #4 rst = 1'b1;
    #1;
    checks++;
    if ({mux_sel, ack, data, err, busy} !== '0) begin
      failures++;
      $display("FAIL resetmid_async got sel=%h ack=%b data=%h err=%b busy=%b exp all zero",
               mux_sel, ack, data, err, busy);
    end
    #4 rst = 1'b0;
    repeat (2) step();
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL resetmid_latency got early ack=%b exp 0000", ack);
    end
    step();
    checks++;
    if (ack !== 4'b0010 || data !== 32'h33) begin
      failures++;
      $display("FAIL resetmid_serve got ack=%b data=%h exp ack=0010 data=33", ack, data);
    end
    req  = 4'b0100;
    addr = 16'h0636;
    step();
    #4 rst = 1'b1;
    #5 rst = 1'b0;
    req = 4'b1001;
    repeat (3) step();
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL resetmid_ptr got ack=%b exp 0001 (pointer 0)", ack);
    end
    req = '0;
    step();
  endtask

  task automatic test_pulse();
    req  = 4'b0010;
    addr = 16'h0030;
    step();
    req = '0;
    step();
    step();
    checks++;
    if (ack !== 4'b0010 || data !== 32'h33) begin
      failures++;
      $display("FAIL pulse_ack got ack=%b data=%h exp ack=0010 data=33", ack, data);
    end
    step();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pulse_idle got ack=%b busy=%b exp ack=0000 busy=0", ack, busy);
    end
  endtask

  task automatic test_random();
    int ptr_m;
    int w;
    logic [3:0]  ea;
    logic [3:0]  exp_ack;
    logic [31:0] exp_d;
    apply_reset();
    ptr_m = 0;
    for (int s = 0; s < 16; s++) mux_table[s] = $urandom;
    addr = 16'($urandom);
    for (int t = 0; t < 200; t++) begin
      if (req == 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            addr[4*i +: 4] = 4'($urandom);
          end
        end
      end
      if (req == 4'b0000) begin
        step();
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
          failures++;
          $display("FAIL random_idle t=%0d got ack=%b busy=%b exp 0000/0", t, ack, busy);
        end
        continue;
      end
      w       = rr_pick(req, ptr_m);
      ea      = addr[4*w +: 4];
      exp_ack = 4'b0001 << w;
      exp_d   = (ea >= 4'hE) ? 32'h0 : mux_table[ea];
      step();
      checks++;
      if (mux_sel !== ea || busy !== 1'b1 || ack !== 4'b0000) begin
        failures++;
        $display("FAIL random_sel t=%0d got sel=%h busy=%b ack=%b exp sel=%h busy=1 ack=0000",
                 t, mux_sel, busy, ack, ea);
      end
      step();
      step();
      checks++;
      if (ack !== exp_ack || data !== exp_d || err !== (ea >= 4'hE) || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_ack t=%0d got ack=%b data=%h err=%b busy=%b exp ack=%b data=%h err=%b busy=0",
                 t, ack, data, err, busy, exp_ack, exp_d, (ea >= 4'hE));
      end
      ptr_m = (w + 1) % 4;
      req[w] = 1'($urandom_range(1));
      if (req[w]) addr[4*w +: 4] = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && i != w && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          addr[4*i +: 4] = 4'($urandom);
        end
      end
    end
    req = '0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    addr     = '0;
    for (int s = 0; s < 16; s++) mux_table[s] = '0;
    test_reset();
    test_single();
    test_rotation();
    test_pointer();
    test_illegal();
    test_reset_mid();
    test_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
